// File: rtl/inv_mix_columns_32.sv
// Iterative AES InvMixColumns engine: one 32-bit column in, LANES result bytes
// computed per cycle from a shared xtime chain, valid/ready on both sides.
module inv_mix_columns_32 #(
    parameter int LANES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] data_in,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] data_out,
    output logic        busy
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] COMPUTE = 2'd1;
    localparam logic [1:0] DONE    = 2'd2;

    // STEP wraps to 0 for LANES=4, which is harmless since that cycle ends COMPUTE.
    localparam logic [1:0] STEP = 2'(LANES);
    localparam logic [1:0] LAST = 2'(4 - LANES);

    generate
        if (!(LANES == 1 || LANES == 2 || LANES == 4)) begin : g_bad_lanes
            $fatal(1, "inv_mix_columns_32: LANES must be 1, 2 or 4");
        end
    endgenerate

    logic [1:0]  state;
    logic [1:0]  idx;
    logic [31:0] col;
    logic [31:0] next_out;
    logic [7:0]  x2 [4];
    logic [7:0]  x4 [4];
    logic [7:0]  x8 [4];
    logic [7:0]  m9 [4];
    logic [7:0]  mb [4];
    logic [7:0]  md [4];
    logic [7:0]  me [4];
    logic [1:0]  k;

    function automatic logic [7:0] xtime(input logic [7:0] v);
        return {v[6:0], 1'b0} ^ (v[7] ? 8'h1B : 8'h00);
    endfunction

    // Every input byte is multiplied by 09/0B/0D/0E once; lanes only select and XOR.
    always_comb begin
        for (int j = 0; j < 4; j++) begin
            x2[j] = xtime(col[(3-j)*8 +: 8]);
            x4[j] = xtime(x2[j]);
            x8[j] = xtime(x4[j]);
            m9[j] = x8[j] ^ col[(3-j)*8 +: 8];
            mb[j] = x8[j] ^ x2[j] ^ col[(3-j)*8 +: 8];
            md[j] = x8[j] ^ x4[j] ^ col[(3-j)*8 +: 8];
            me[j] = x8[j] ^ x4[j] ^ x2[j];
        end
    end

    // Row k uses row 0's coefficients rotated right by k; ~k selects byte lane 3-k.
    always_comb begin
        next_out = data_out;
        k        = 2'd0;
        for (int l = 0; l < LANES; l++) begin
            k = idx + 2'(l);
            next_out[{~k, 3'b000} +: 8] = me[k] ^ mb[k + 2'd1] ^ md[k + 2'd2] ^ m9[k + 2'd3];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            idx      <= 2'd0;
            col      <= 32'h0;
            data_out <= 32'h0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        col      <= data_in;
                        data_out <= 32'h0;
                        idx      <= 2'd0;
                        state    <= COMPUTE;
                    end
                end
                COMPUTE: begin
                    data_out <= next_out;
                    idx      <= idx + STEP;
                    if (idx == LAST) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state == IDLE) && !rst;
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);

endmodule
